// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Misses move whole lines word by word over a req/ack backing-memory port;
// a flush walks every set and writes back the dirty ones. Hit and miss
// counters saturate at all-ones.
module dcache_wb_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SET_BITS  = 9,
  parameter int WORD_BITS = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clock_me,
  input  logic              reset_0,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rmem,
  input  logic              wmem,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              stall_me,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int TAG_W      = ADDR_W - SET_BITS - WORD_BITS - 2;
  localparam int SETS       = 1 << SET_BITS;
  localparam int LINE_WORDS = 1 << WORD_BITS;

  typedef enum logic [2:0] {IDLE, WB, FILL, FL_SCAN, FL_WB} state_t;

  state_t state, next_state;

  logic [DATA_W-1:0]    data_mem [SETS*LINE_WORDS];
  logic [TAG_W-1:0]     tag_mem  [SETS];
  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [WORD_BITS-1:0] word_q;
  logic [SET_BITS-1:0]  scan_set;

  logic [TAG_W-1:0]     a_tag;
  logic [SET_BITS-1:0]  a_set;
  logic [WORD_BITS-1:0] a_word;
  logic [SET_BITS-1:0]  wb_set;
  logic                 access, hit, word_ack, line_done;
  logic                 scan_dirty, last_set, xfer_state;
  logic                 unused_byte_sel;

  assign a_tag           = addr[ADDR_W-1 -: TAG_W];
  assign a_set           = addr[WORD_BITS+2 +: SET_BITS];
  assign a_word          = addr[2 +: WORD_BITS];
  assign unused_byte_sel = ^addr[1:0];

  assign access     = rmem | wmem;
  assign hit        = valid_q[a_set] && (tag_mem[a_set] == a_tag);
  assign word_ack   = mem_req & mem_ack;
  assign line_done  = word_ack & (&word_q);
  assign scan_dirty = valid_q[scan_set] & dirty_q[scan_set];
  assign last_set   = &scan_set;
  assign xfer_state = (state == WB) || (state == FILL) || (state == FL_WB);
  assign wb_set     = (state == FL_WB) ? scan_set : a_set;

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clock_me or posedge reset_0) begin
    if (reset_0) state <= IDLE;
    else         state <= next_state;
  end

  // Next state: a miss always beats a simultaneous flush request.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (access && !hit)
          next_state = (valid_q[a_set] && dirty_q[a_set]) ? WB : FILL;
        else if (flush_req && !access)
          next_state = FL_SCAN;
      end
      WB:      if (line_done) next_state = FILL;
      FILL:    if (line_done) next_state = IDLE;
      FL_SCAN: begin
        if (scan_dirty)    next_state = FL_WB;
        else if (last_set) next_state = IDLE;
      end
      FL_WB:   if (line_done) next_state = FL_SCAN;
      default: next_state = IDLE;
    endcase
  end

  // Combinational outputs: pipeline stall, memory-port fields and load data.
  always_comb begin
    stall_me  = (state == IDLE) ? (access & ~hit) : access;
    mem_we    = (state == WB) || (state == FL_WB);
    if (state == FILL)
      mem_addr = {a_tag, a_set, word_q, 2'b00};
    else
      mem_addr = {tag_mem[wb_set], wb_set, word_q, 2'b00};
    mem_wdata = data_mem[{wb_set, word_q}];
    data_out  = data_mem[{a_set, a_word}];
  end

  // Transfer sequencing, flush walk, line status bits and statistics.
  always_ff @(posedge clock_me or posedge reset_0) begin
    if (reset_0) begin
      mem_req    <= 1'b0;
      word_q     <= '0;
      scan_set   <= '0;
      flush_done <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      mem_req    <= xfer_state && !line_done;
      flush_done <= (state == FL_SCAN) && !scan_dirty && last_set;

      if (state == IDLE)  word_q <= '0;
      else if (word_ack)  word_q <= word_q + WORD_BITS'(1);

      if (state == IDLE)
        scan_set <= '0;
      else if (state == FL_SCAN && !scan_dirty && !last_set)
        scan_set <= scan_set + SET_BITS'(1);

      if (state == IDLE && wmem && hit)
        dirty_q[a_set] <= 1'b1;
      if (state == FILL && line_done) begin
        valid_q[a_set] <= 1'b1;
        dirty_q[a_set] <= 1'b0;
      end
      if (state == FL_WB && line_done)
        dirty_q[scan_set] <= 1'b0;

      if (state == IDLE && access && hit && hit_cnt != {CNT_W{1'b1}})
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (state == IDLE && access && !hit && miss_cnt != {CNT_W{1'b1}})
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  // Line storage: store hits and fill words land here; contents survive reset.
  always_ff @(posedge clock_me) begin
    if (state == IDLE && wmem && hit)
      data_mem[{a_set, a_word}] <= data_in;
    if (state == FILL && word_ack)
      data_mem[{a_set, word_q}] <= mem_rdata;
    if (state == FILL && line_done)
      tag_mem[a_set] <= a_tag;
  end

endmodule
